frame_encoder: RTL and testbench

Transmit-side counterpart of the decoder's frame slicer. It takes a serial information-bit stream, applies K=3 convolutional encoding at rate 1/2 or 1/3, appends the two zero tail bits, and packs the coded symbols MSB-first into 276-bit frames. Bit order matches what the slicer consumes. It sits between the PS-side bit source and the frame buffer and channel model that feed the Viterbi decoder path.

---
 rtl/param_def.sv | 9 +
 rtl/conv_enc_core.sv | 29 ++
 rtl/frame_encoder.sv | 96 +++++++++
 tb/tb_frame_encoder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/param_def.sv
// param_def: shared constants and state encoding for the frame encoder
package param_def;
    localparam int FRAME_W = 276;
    localparam int CAP2 = FRAME_W / 2;
    localparam int CAP3 = FRAME_W / 3;
    localparam logic CODE_RATE_2 = 1'b0;
    localparam logic CODE_RATE_3 = 1'b1;
    typedef enum logic [1:0] {IDLE, FILL, FLUSH, HOLD} state_t;
endpackage

// File: rtl/conv_enc_core.sv
// conv_enc_core: K=3 convolutional encoder state with g=7/5/3 code outputs
module conv_enc_core (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    input  logic i_b,
    output logic o_c0,
    output logic o_c1,
    output logic o_c2
);
    logic r_s1, r_s0;
    // shift the newest bit in; clear wins so a new stream starts from the zero state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s0 <= 1'b0;
        end else if (i_clr) begin
            r_s1 <= 1'b0;
            r_s0 <= 1'b0;
        end else if (i_en) begin
            r_s1 <= i_b;
            r_s0 <= r_s1;
        end
    end
    assign o_c0 = i_b ^ r_s1 ^ r_s0;
    assign o_c1 = i_b ^ r_s0;
    assign o_c2 = i_b ^ r_s1;
endmodule

// File: rtl/frame_encoder.sv
// frame_encoder: convolutionally encodes a bit stream plus tail and packs symbols MSB-first into frames
module frame_encoder
    import param_def::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_code_rate,
    input  logic               i_bit,
    input  logic               i_valid,
    input  logic               i_last,
    output logic               o_ready,
    output logic [FRAME_W-1:0] o_data_frame,
    output logic               o_frame_valid,
    input  logic               i_frame_ready,
    output logic [8:0]         o_frame_bits,
    output logic               o_last_frame
);
    state_t r_state, w_next;
    logic r_up, r_rate, r_final, w_final, w_clr;
    logic [7:0] r_cnt;
    logic [1:0] r_tail, w_tail;
    logic [FRAME_W-1:0] r_frame, w_ins;
    logic [8:0] w_bits;
    logic w_accept, w_flush, w_write, w_take, w_rate, w_full, w_b, w_c0, w_c1, w_c2;

    assign o_ready = r_up && (r_state == IDLE || r_state == FILL);
    assign w_accept = o_ready && i_valid;
    assign w_flush = r_state == FLUSH;
    assign w_write = w_accept || w_flush;
    assign w_take = r_state == HOLD && i_frame_ready;
    assign w_rate = (r_state == IDLE) ? i_code_rate : r_rate;
    assign w_b = i_bit && !w_flush;
    assign w_full = r_cnt == 8'((w_rate == CODE_RATE_2 ? CAP2 : CAP3) - 1);
    assign w_bits = (r_rate == CODE_RATE_3) ? {1'b0, r_cnt} * 9'd3 : {r_cnt, 1'b0};
    assign w_ins = {w_c0, w_c1, w_c2 & (w_rate == CODE_RATE_3), {(FRAME_W-3){1'b0}}} >> w_bits;
    assign o_data_frame = r_frame;
    assign o_frame_valid = r_state == HOLD;
    assign o_frame_bits = w_bits;
    assign o_last_frame = r_final && r_state == HOLD;

    conv_enc_core u_core (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_write),
        .i_clr (w_clr),
        .i_b   (w_b),
        .o_c0  (w_c0),
        .o_c1  (w_c1),
        .o_c2  (w_c2)
    );

    // next state: a full frame always parks in HOLD, even mid-tail
    always_comb begin
        w_next = r_state;
        w_tail = r_tail;
        w_final = r_final;
        w_clr = 1'b0;
        case (r_state)
            IDLE, FILL: if (w_accept) begin
                w_tail = i_last ? 2'd2 : r_tail;
                w_next = w_full ? HOLD : (i_last ? FLUSH : FILL);
            end
            FLUSH: begin
                w_tail = r_tail - 2'd1;
                w_final = r_tail == 2'd1;
                w_next = (r_tail == 2'd1 || w_full) ? HOLD : FLUSH;
            end
            default: if (i_frame_ready) begin
                w_next = (r_tail != 2'd0) ? FLUSH : (r_final ? IDLE : FILL);
                w_final = 1'b0;
                w_clr = r_final;
            end
        endcase
    end

    // state, symbol count, tail count, rate latch and frame insert register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_up <= 1'b0;
            r_state <= IDLE;
            r_tail <= 2'd0;
            r_final <= 1'b0;
            r_rate <= CODE_RATE_2;
            r_cnt <= 8'd0;
            r_frame <= '0;
        end else begin
            r_up <= 1'b1;
            r_state <= w_next;
            r_tail <= w_tail;
            r_final <= w_final;
            r_rate <= (r_state == IDLE && w_accept) ? i_code_rate : r_rate;
            r_cnt <= w_take ? 8'd0 : r_cnt + 8'(w_write);
            r_frame <= w_take ? '0 : (w_write ? r_frame | w_ins : r_frame);
        end
    end
endmodule

// File: tb/tb_frame_encoder.sv
// tb_frame_encoder: directed streams checked against a bit-history model of the encoder
module tb_frame_encoder;
    localparam int FW = 276;
    typedef struct {
        logic [FW-1:0] d;
        int            bits;
        bit            last;
    } frame_t;

    logic clk = 0, rst = 1, i_code_rate = 0, i_bit = 0, i_valid = 0, i_last = 0, i_frame_ready = 1;
    logic o_ready, o_frame_valid, o_last_frame;
    logic [FW-1:0] o_data_frame, snap;
    logic [8:0] o_frame_bits;
    int n_run = 0, n_fail = 0;
    frame_t exp_q[$], got_q[$];
    frame_t gf, g, g1;
    bit stim[$];

    frame_encoder dut (
        .clk           (clk),
        .rst           (rst),
        .i_code_rate   (i_code_rate),
        .i_bit         (i_bit),
        .i_valid       (i_valid),
        .i_last        (i_last),
        .o_ready       (o_ready),
        .o_data_frame  (o_data_frame),
        .o_frame_valid (o_frame_valid),
        .i_frame_ready (i_frame_ready),
        .o_frame_bits  (o_frame_bits),
        .o_last_frame  (o_last_frame)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // coded bits come straight from the generator taps over the input history (tail zeros appended)
    task automatic model(input bit rate);
        bit u[$];
        bit cb[$];
        frame_t f;
        u = stim;
        u.push_back(1'b0);
        u.push_back(1'b0);
        for (int k = 0; k < u.size(); k++) begin
            bit p1, p2;
            p1 = (k > 0) ? u[k-1] : 1'b0;
            p2 = (k > 1) ? u[k-2] : 1'b0;
            cb.push_back(u[k] ^ p1 ^ p2);
            cb.push_back(u[k] ^ p2);
            if (rate) cb.push_back(u[k] ^ p1);
        end
        for (int s = 0; s < cb.size(); s += FW) begin
            f.d = '0;
            f.bits = (cb.size() - s < FW) ? cb.size() - s : FW;
            for (int j = 0; j < f.bits; j++) f.d[FW-1-j] = cb[s+j];
            f.last = (s + FW >= cb.size());
            exp_q.push_back(f);
        end
    endtask

    task automatic fill_pattern(input int n);
        stim.delete();
        for (int k = 0; k < n; k++) stim.push_back(((k * 7 + 3) % 5) < 2);
    endtask

    task automatic drive(input bit rate, input int lo, input int hi, input bit last);
        for (int k = lo; k < hi; k++) begin
            bit acc;
            int t;
            i_valid = 1;
            i_bit = stim[k];
            i_last = last && (k == hi - 1);
            i_code_rate = (k == 0) ? rate : ~rate;
            t = 0;
            do begin
                acc = o_ready;
                @(posedge clk);
                #1;
                t++;
            end while (!acc && t < 1000);
            if (!acc) begin
                n_run++;
                n_fail++;
                $display("FAIL accept_timeout: bit %0d not accepted within 1000 cycles", k);
                i_valid = 0;
                i_last = 0;
                return;
            end
        end
        i_valid = 0;
        i_last = 0;
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk({name, "_frames_left"}, exp_q.size(), 0);
        chk({name, "_ready_idle"}, o_ready, 1);
    endtask

    task automatic got_last(input int back, output frame_t f);
        f.d = '0;
        f.bits = -1;
        f.last = 0;
        if (got_q.size() > back) f = got_q[got_q.size() - 1 - back];
    endtask

    // every HOLD cycle must present exactly the model's next frame
    always @(negedge clk) begin
        if (!rst && o_frame_valid) begin
            if (exp_q.size() == 0) begin
                n_run++;
                n_fail++;
                $display("FAIL unexpected_frame: got frame_valid=1 required 0");
            end else begin
                chk("frame_data", o_data_frame, exp_q[0].d);
                chk("frame_bits", o_frame_bits, exp_q[0].bits);
                chk("last_frame", o_last_frame, exp_q[0].last);
                chk("ready_in_hold", o_ready, 0);
                if (i_frame_ready) begin
                    gf.d = o_data_frame;
                    gf.bits = int'(o_frame_bits);
                    gf.last = o_last_frame;
                    got_q.push_back(gf);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #2;
        chk("rst_ready", o_ready, 0);
        chk("rst_valid", o_frame_valid, 0);
        chk("rst_data", o_data_frame, 0);
        chk("rst_bits", o_frame_bits, 0);
        chk("rst_last", o_last_frame, 0);
        @(posedge clk);
        #1;
        rst = 0;
        #1;
        chk("ready_before_edge", o_ready, 0);
        @(posedge clk);
        #1;
        chk("ready_after_reset", o_ready, 1);

        stim = {1'b1, 1'b0, 1'b1, 1'b1};
        model(0);
        chk("model_s1_head", exp_q[0].d[275:264], 12'hE17);
        drive(0, 0, 4, 1);
        wait_done("s1");
        got_last(0, g);
        chk("s1_head", g.d[275:264], 12'hE17);
        chk("s1_rest_zero", g.d[263:0], 0);
        chk("s1_bits", g.bits, 12);
        chk("s1_last", g.last, 1);

        stim = {1'b1};
        model(1);
        chk("model_s2_head", exp_q[0].d[275:267], 9'b111101110);
        drive(1, 0, 1, 1);
        wait_done("s2");
        got_last(0, g);
        chk("s2_head", g.d[275:267], 9'b111101110);
        chk("s2_bits", g.bits, 9);
        chk("s2_last", g.last, 1);

        fill_pattern(139);
        model(0);
        i_frame_ready = 0;
        drive(0, 0, 138, 0);
        chk("full_valid", o_frame_valid, 1);
        chk("full_ready", o_ready, 0);
        chk("full_bits", o_frame_bits, 276);
        chk("full_last", o_last_frame, 0);
        snap = o_data_frame;
        for (int c = 0; c < 10; c++) begin
            i_valid = 1;
            i_bit = ~i_bit;
            @(posedge clk);
            #1;
            chk("bp_ready", o_ready, 0);
            chk("bp_valid", o_frame_valid, 1);
            chk("bp_stable", o_data_frame, snap);
        end
        i_valid = 0;
        i_frame_ready = 1;
        drive(0, 138, 139, 1);
        wait_done("s3");
        got_last(0, g);
        chk("s3_bits", g.bits, 6);
        chk("s3_last", g.last, 1);

        fill_pattern(137);
        model(0);
        drive(0, 0, 137, 1);
        wait_done("s4");
        got_last(1, g1);
        got_last(0, g);
        chk("s4_f1_bits", g1.bits, 276);
        chk("s4_f1_last", g1.last, 0);
        chk("s4_f2_bits", g.bits, 2);
        chk("s4_f2_last", g.last, 1);
        chk("s4_tail2", g.d[275:274], {stim[136], stim[136]});

        fill_pattern(50);
        drive(0, 0, 50, 0);
        rst = 1;
        #1;
        chk("mid_rst_ready", o_ready, 0);
        chk("mid_rst_valid", o_frame_valid, 0);
        chk("mid_rst_data", o_data_frame, 0);
        chk("mid_rst_bits", o_frame_bits, 0);
        chk("mid_rst_last", o_last_frame, 0);
        @(posedge clk);
        #1;
        rst = 0;
        @(posedge clk);
        #1;
        chk("ready_after_mid_rst", o_ready, 1);
        stim = {1'b1, 1'b0, 1'b1, 1'b1};
        model(0);
        drive(0, 0, 4, 1);
        wait_done("s5");
        got_last(0, g);
        chk("s5_head", g.d[275:264], 12'hE17);
        chk("s5_rest_zero", g.d[263:0], 0);
        chk("s5_bits", g.bits, 12);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
